jtlt_pulse_arbiter: RTL and testbench

//  Shares one toggle-type JTL cell (JTLT: every edge on its input emits a pulse and toggles its output)

---
 rtl/jtlt_pulse_arbiter.sv | 142 ++++++++++++++
 tb/tb_jtlt_pulse_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtlt_pulse_arbiter.sv
// Round-robin arbiter that shares one toggle-type JTL cell between N_REQ requesters,
// enforcing warm-up and inter-pulse spacing and checking the cell's echoed output.
module jtlt_pulse_arbiter #(
    parameter int N_REQ         = 4,
    parameter int WARMUP_CYCLES = 8,
    parameter int GAP_CYCLES    = 2,
    parameter int ECHO_CYCLES   = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             q_in,
    output logic [N_REQ-1:0] grant,
    output logic             a_out,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int SUM_W   = PTR_W + 1;
    localparam int TMR_MAX = (WARMUP_CYCLES > GAP_CYCLES) ? WARMUP_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_IDLE,
        ST_GAP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]   w_gnt_idx, w_cand;
    logic [SUM_W-1:0]   w_cand_sum, w_ptr_sum;
    logic               w_found, w_issue;
    logic [N_REQ-1:0]   r_grant, w_gnt_oh;
    logic               r_a_out, r_busy, r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [ECHO_CYCLES-1:0] r_echo;
    logic [ECHO_CYCLES:0]   w_echo_chain;

    // Rotating priority search; scanning from the far end lets the nearest
    // requester to the pointer overwrite the others without an early exit.
    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no latch is inferred.
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_cand_sum = '0;
        w_cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand_sum = {1'b0, r_ptr} + SUM_W'(k);
            if (w_cand_sum >= SUM_W'(N_REQ)) begin
                w_cand_sum = w_cand_sum - SUM_W'(N_REQ);
            end
            w_cand = w_cand_sum[PTR_W-1:0];
            if (req[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_gnt_oh  = N_REQ'(1) << w_gnt_idx;
    assign w_ptr_sum = {1'b0, w_gnt_idx} + SUM_W'(1);
    assign w_ptr_nxt = (w_ptr_sum >= SUM_W'(N_REQ)) ? '0 : w_ptr_sum[PTR_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_issue     = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (r_tmr == TMR_W'(WARMUP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            ST_IDLE: begin
                if (w_found) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_GAP;
                    w_tmr_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (r_tmr == TMR_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_WARMUP;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    assign w_echo_chain = {r_echo, r_a_out};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WARMUP;
            r_tmr   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_a_out <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_echo  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_grant <= w_issue ? w_gnt_oh : '0;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_echo  <= w_echo_chain[ECHO_CYCLES-1:0];
            if (w_issue) begin
                r_a_out <= ~r_a_out;
                r_cnt   <= r_cnt + CNT_W'(1);
                r_ptr   <= w_ptr_nxt;
            end
            // The cell's q is undefined until warm-up completes.
            if (r_state != ST_WARMUP && q_in != r_echo[ECHO_CYCLES-1]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign grant     = r_grant;
    assign a_out     = r_a_out;
    assign busy      = r_busy;
    assign err       = r_err;
    assign pulse_cnt = r_cnt;

endmodule

// File: tb/tb_jtlt_pulse_arbiter.sv
// Bench for jtlt_pulse_arbiter: vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-count reference model.
module tb_jtlt_pulse_arbiter;

    localparam int N      = 4;
    localparam int WARMUP = 8;
    localparam int GAP    = 2;
    localparam int ECHO   = 1;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          q_in = 1'b0;
    logic [N-1:0]  grant;
    logic          a_out, busy, err;
    logic [CW-1:0] pulse_cnt;

    jtlt_pulse_arbiter #(
        .N_REQ(N), .WARMUP_CYCLES(WARMUP), .GAP_CYCLES(GAP), .ECHO_CYCLES(ECHO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .q_in(q_in),
        .grant(grant), .a_out(a_out), .busy(busy), .err(err), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges counted since reset release; a grant is legal from edge next_ok on.
    int           e, next_ok, m_ptr, m_cnt;
    bit           m_a, m_err, m_busy, q_follow;
    logic [N-1:0] m_grant;
    bit           m_hist [0:4095];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
        logic         a_out;
        logic         busy;
    } vec_t;
    vec_t tbl [15];

    function automatic bit hist(input int k);
        return (k < 0) ? 1'b0 : m_hist[k];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0; next_ok = WARMUP + 1; m_ptr = 0; m_cnt = 0;
        m_a = 0; m_err = 0; m_busy = 1; m_grant = '0; q_follow = 0;
    endtask

    // Asserts reset at the current (off-edge) time, checks the asynchronous reset values,
    // then releases on a falling edge so the next rising edge is edge 1.
    task automatic do_reset();
        rst_n = 1'b0; req = '0; q_in = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_a_out", a_out, 0);
        check("rst_busy", busy, 1);
        check("rst_err", err, 0);
        check("rst_cnt", pulse_cnt, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, advance the model on the rising edge, compare, return at negedge.
    task automatic step(input logic [N-1:0] r, input bit inj);
        logic [N-1:0] rs;
        bit qs, prev_a;
        int w;
        req = r;
        q_in = inj ? 1'b0 : q_follow;
        rs = r; qs = q_in; prev_a = a_out;
        @(posedge clk); #1;
        e++;
        if (e > WARMUP && qs != hist(e - 1 - ECHO)) m_err = 1;
        m_grant = '0;
        w = -1;
        if (e >= next_ok) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && rs[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        if (w >= 0) begin
            m_grant = N'(1) << w;
            m_a     = ~m_a;
            m_cnt   = (m_cnt + 1) % (1 << CW);
            m_ptr   = (w + 1) % N;
            next_ok = e + GAP + 1;
        end
        m_hist[e] = m_a;
        m_busy    = (e + 1 < next_ok);
        check("grant", grant, m_grant);
        check("a_out", a_out, m_a);
        check("busy", busy, m_busy);
        check("err", err, m_err);
        check("pulse_cnt", pulse_cnt, m_cnt);
        q_follow = prev_a;
        @(negedge clk);
    endtask

    initial begin
        bit done;

        tbl[0]  = '{4'hF, 4'b0001, 1'b1, 1'b1};
        tbl[1]  = '{4'hF, 4'b0000, 1'b1, 1'b1};
        tbl[2]  = '{4'hF, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{4'hF, 4'b0010, 1'b0, 1'b1};
        tbl[4]  = '{4'hF, 4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{4'hF, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'hF, 4'b0100, 1'b1, 1'b1};
        tbl[7]  = '{4'hF, 4'b0000, 1'b1, 1'b1};
        tbl[8]  = '{4'hF, 4'b0000, 1'b1, 1'b0};
        tbl[9]  = '{4'hF, 4'b1000, 1'b0, 1'b1};
        tbl[10] = '{4'hF, 4'b0000, 1'b0, 1'b1};
        tbl[11] = '{4'hF, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{4'hF, 4'b0001, 1'b1, 1'b1};
        tbl[13] = '{4'hF, 4'b0000, 1'b1, 1'b1};
        tbl[14] = '{4'hF, 4'b0000, 1'b1, 1'b0};

        @(negedge clk);

        // Warm-up blocks a request held from cycle 0; first grant on edge 9.
        do_reset();
        for (int i = 0; i < WARMUP; i++) begin
            step(4'b0001, 0);
            check("t1_no_grant", grant, 0);
        end
        step(4'b0001, 0);
        check("t1_grant", grant, 4'b0001);
        check("t1_a_out", a_out, 1);
        check("t1_cnt", pulse_cnt, 1);

        // Round-robin under continuous requests, from the vector table.
        do_reset();
        for (int i = 0; i < WARMUP; i++) step('0, 0);
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].req, 0);
            check("t2_grant", grant, tbl[i].grant);
            check("t2_a_out", a_out, tbl[i].a_out);
            check("t2_busy", busy, tbl[i].busy);
        end
        check("t2_cnt", pulse_cnt, 5);

        // Echo check: 100 pulses clean, then a single forced q_in=0 while the echo is 1.
        do_reset();
        for (int i = 0; i < WARMUP + 1 + 3 * 99; i++) step(4'hF, 0);
        check("t3_cnt", pulse_cnt, 100);
        check("t3_err_clean", err, 0);
        done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (hist(e - ECHO)) begin
                step(4'hF, 1);
                done = 1;
            end else begin
                step(4'hF, 0);
            end
        end
        check("t3_inject_found", done, 1);
        check("t3_err_set", err, 1);
        for (int i = 0; i < 5; i++) step(4'hF, 0);
        check("t3_err_sticky", err, 1);

        // Counter wrap after 257 pulses.
        do_reset();
        for (int i = 0; i < WARMUP + 1 + 3 * 256; i++) step(4'hF, 0);
        check("t4_cnt_wrap", pulse_cnt, 1);
        check("t4_parity", a_out, 1);

        // Request withdrawn during the gap never produces a pulse.
        do_reset();
        for (int i = 0; i < WARMUP; i++) step('0, 0);
        step(4'b0001, 0);
        check("t5_first", grant, 4'b0001);
        step(4'b0100, 0);
        check("t5_gap_grant", grant, 0);
        step(4'b0000, 0);
        check("t5_busy_fall", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 0);
            check("t5_no_grant", grant, 0);
            check("t5_a_hold", a_out, 1);
        end

        // Reset mid-gap with a_out=1 discards everything and re-runs warm-up.
        do_reset();
        for (int i = 0; i < WARMUP; i++) step('0, 0);
        step(4'b0001, 0);
        check("t6_pre_a", a_out, 1);
        check("t6_pre_busy", busy, 1);
        do_reset();
        for (int i = 0; i < WARMUP; i++) begin
            step(4'hF, 0);
            check("t6_warm_no_grant", grant, 0);
        end
        step(4'hF, 0);
        check("t6_regrant", grant, 4'b0001);

        // Randomized traffic with occasional q_in glitches, all checked by the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
